delay_counter_4ch: RTL and testbench

- Downstream stage of the start/discharge front end.
- Consumes the front end's start-counter level and measures a programmed delay per channel in i_clk cycles.
- When a channel's delay elapses, asserts that channel's end-of-delay line. That line drives the front end's per-channel reset input, ending the channel's discharge.
- Reports run status (busy, done, abort) to the control logic.

---
 rtl/delay_counter_4ch.sv | 174 +++++++++++++++++
 tb/tb_delay_counter_4ch.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_counter_4ch.sv
// ---------------------------------------------------------------------------
// delay_counter_4ch
//
// Per-channel programmable delay timer that sits behind the start/discharge
// front end. While the front end holds i_startcounter high, a shared cycle
// counter runs. Each channel raises its end-of-delay line when the counter
// reaches that channel's programmed delay. The end-of-delay line feeds the
// front end's per-channel reset and ends that channel's discharge. Once
// every channel has fired, the run parks in DONE until i_startcounter drops.
//
// Ports
//   i_clk           system clock, rising-edge active
//   i_reset         asynchronous, active-high reset
//   i_startcounter  run request level from the front end
//   i_delay         per-channel delay in cycles, channel i at [i*CNT_W +: CNT_W]
//   i_ch_en         per-channel enable; disabled channels fire on the first
//                   RUN edge so that they never hold the run open
//   o_reset_ch      per-channel end-of-delay level, sticky until the run ends
//   o_count         current cycle count (saturating)
//   o_busy          high while running
//   o_done          high while parked with all channels fired
//   o_abort         one-cycle pulse when a run is dropped before completion
// ---------------------------------------------------------------------------
module delay_counter_4ch #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 16
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_startcounter,
    input  logic [N_CH*CNT_W-1:0]   i_delay,
    input  logic [N_CH-1:0]         i_ch_en,
    output logic [N_CH-1:0]         o_reset_ch,
    output logic [CNT_W-1:0]        o_count,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_abort
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [1:0]              r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [N_CH*CNT_W-1:0]   r_dly;
    logic [N_CH-1:0]         r_en;
    logic [N_CH-1:0]         r_reset_ch;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_abort;

    logic [1:0]              w_state_nxt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic [N_CH*CNT_W-1:0]   w_dly_nxt;
    logic [N_CH-1:0]         w_en_nxt;
    logic [N_CH-1:0]         w_reset_ch_nxt;
    logic                    w_abort_nxt;
    logic [N_CH-1:0]         w_hit;
    logic [N_CH-1:0]         w_fired;
    logic [CNT_W-1:0]        w_cnt_inc;

    // Per-channel match against the snapshot; disabled channels always match.
    always_comb begin
        w_hit = {N_CH{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            if (!r_en[i]) begin
                w_hit[i] = 1'b1;
            end else if (r_cnt == r_dly[i*CNT_W +: CNT_W]) begin
                w_hit[i] = 1'b1;
            end else begin
                w_hit[i] = 1'b0;
            end
        end
    end

    // Sticky fired set including this edge's matches, and saturating increment.
    // The match uses the pre-increment count, so a delay of CNT_MAX still fires.
    always_comb begin
        w_fired = r_reset_ch | w_hit;
        if (r_cnt == CNT_MAX) begin
            w_cnt_inc = r_cnt;
        end else begin
            w_cnt_inc = r_cnt + CNT_ONE;
        end
    end

    // Next-state logic; dropping i_startcounter in RUN wins over any match.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_dly_nxt      = r_dly;
        w_en_nxt       = r_en;
        w_reset_ch_nxt = r_reset_ch;
        w_abort_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt      = CNT_ZERO;
                w_reset_ch_nxt = {N_CH{1'b0}};
                if (i_startcounter) begin
                    w_state_nxt = ST_RUN;
                    w_dly_nxt   = i_delay;
                    w_en_nxt    = i_ch_en;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!i_startcounter) begin
                    w_state_nxt    = ST_IDLE;
                    w_cnt_nxt      = CNT_ZERO;
                    w_reset_ch_nxt = {N_CH{1'b0}};
                    w_abort_nxt    = 1'b1;
                end else begin
                    w_cnt_nxt      = w_cnt_inc;
                    w_reset_ch_nxt = w_fired;
                    if (&w_fired) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            ST_DONE: begin
                if (!i_startcounter) begin
                    w_state_nxt    = ST_IDLE;
                    w_cnt_nxt      = CNT_ZERO;
                    w_reset_ch_nxt = {N_CH{1'b0}};
                end else begin
                    w_state_nxt    = ST_DONE;
                end
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_cnt_nxt      = CNT_ZERO;
                w_reset_ch_nxt = {N_CH{1'b0}};
            end
        endcase
    end

    // State, snapshot and registered status outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= CNT_ZERO;
            r_dly      <= {(N_CH*CNT_W){1'b0}};
            r_en       <= {N_CH{1'b0}};
            r_reset_ch <= {N_CH{1'b0}};
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_abort    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_dly      <= w_dly_nxt;
            r_en       <= w_en_nxt;
            r_reset_ch <= w_reset_ch_nxt;
            r_busy     <= (w_state_nxt == ST_RUN);
            r_done     <= (w_state_nxt == ST_DONE);
            r_abort    <= w_abort_nxt;
        end
    end

    assign o_reset_ch = r_reset_ch;
    assign o_count    = r_cnt;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_abort    = r_abort;

endmodule

// File: tb/tb_delay_counter_4ch.sv
// ---------------------------------------------------------------------------
// tb_delay_counter_4ch
//
// Self-checking bench for delay_counter_4ch. It drives a default 16-bit
// instance and a 4-bit-counter instance for the saturation case. Expected
// values come from directed tables and sequences, and from a reference model.
// The model predicts each channel's firing edge arithmetically, as delay+1
// for an enabled channel and 1 for a disabled one, counting edges from the
// start edge.
// ---------------------------------------------------------------------------
module tb_delay_counter_4ch;

    logic        clk;
    logic        rst;
    logic        start;
    logic [63:0] dly;
    logic [3:0]  en;
    logic [3:0]  o_ch;
    logic [15:0] o_cnt;
    logic        o_busy, o_done, o_abort;

    logic        start4;
    logic [15:0] dly4;
    logic [3:0]  en4;
    logic [3:0]  o_ch4;
    logic [3:0]  o_cnt4;
    logic        o_busy4, o_done4, o_abort4;

    int n_tests = 0;
    int n_fail  = 0;

    delay_counter_4ch u_dut (
        .i_clk(clk), .i_reset(rst), .i_startcounter(start),
        .i_delay(dly), .i_ch_en(en),
        .o_reset_ch(o_ch), .o_count(o_cnt),
        .o_busy(o_busy), .o_done(o_done), .o_abort(o_abort)
    );

    delay_counter_4ch #(.N_CH(4), .CNT_W(4)) u_dut4 (
        .i_clk(clk), .i_reset(rst), .i_startcounter(start4),
        .i_delay(dly4), .i_ch_en(en4),
        .o_reset_ch(o_ch4), .o_count(o_cnt4),
        .o_busy(o_busy4), .o_done(o_done4), .o_abort(o_abort4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic [63:0] dly;
        logic [3:0]  en;
        logic [3:0]  ch;
        logic [15:0] cnt;
        logic        busy;
        logic        done;
        logic        abort;
    } vec_t;

    vec_t vecs [15];

    function automatic vec_t mk(logic s, logic [63:0] d, logic [3:0] e, logic [3:0] ch,
                                logic [15:0] c, logic b, logic dn, logic ab);
        vec_t v;
        v.start = s; v.dly = d; v.en = e; v.ch = ch;
        v.cnt = c; v.busy = b; v.done = dn; v.abort = ab;
        return v;
    endfunction

    function automatic logic [31:0] pk(logic [3:0] ch, logic [15:0] c, logic b, logic dn, logic ab);
        return {9'd0, ch, c, b, dn, ab};
    endfunction

    function automatic logic [31:0] got_main();
        return pk(o_ch, o_cnt, o_busy, o_done, o_abort);
    endfunction

    function automatic logic [31:0] got_w4();
        return pk(o_ch4, {12'd0, o_cnt4}, o_busy4, o_done4, o_abort4);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got ch=%b cnt=%0d busy=%b done=%b abort=%b, want ch=%b cnt=%0d busy=%b done=%b abort=%b",
                     name, got[22:19], got[18:3], got[2], got[1], got[0],
                     exp[22:19], exp[18:3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked then too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    // ---------------- reference model (random phase) ----------------
    bit m_active, m_finished, m_abort;
    int m_k, m_last;
    int m_fire [4];

    task automatic model_edge(input logic s, input logic [63:0] d, input logic [3:0] e);
        m_abort = 1'b0;
        if (!m_active) begin
            if (s) begin
                m_active = 1'b1; m_finished = 1'b0; m_k = 0; m_last = 0;
                for (int i = 0; i < 4; i++) begin
                    m_fire[i] = e[i] ? int'(d[i*16 +: 16]) + 1 : 1;
                    if (m_fire[i] > m_last) m_last = m_fire[i];
                end
            end
        end else if (!s) begin
            m_abort  = !m_finished;
            m_active = 1'b0;
        end else if (!m_finished) begin
            m_k++;
            if (m_k >= m_last) m_finished = 1'b1;
        end
    endtask

    function automatic logic [31:0] model_out();
        logic [3:0]  ch;
        logic [15:0] c;
        ch = 4'b0000;
        c  = 16'd0;
        if (m_active) begin
            for (int i = 0; i < 4; i++) ch[i] = (m_k >= m_fire[i]);
            c = (m_k > 65535) ? 16'hFFFF : 16'(m_k);
        end
        return pk(ch, c, m_active && !m_finished, m_active && m_finished, m_abort);
    endfunction

    initial begin
        logic [3:0]  ech;
        logic [15:0] ecnt;
        int          kk;
        logic [63:0] d2, d3;

        rst = 1'b1; start = 1'b0; dly = 64'd0; en = 4'd0;
        start4 = 1'b0; dly4 = 16'd0; en4 = 4'd0;
        #3;
        check("reset_state", got_main(), pk(4'b0000, 16'd0, 1'b0, 1'b0, 1'b0));
        check("reset_state_w4", got_w4(), pk(4'b0000, 16'd0, 1'b0, 1'b0, 1'b0));
        #9;
        rst = 1'b0;

        // ---------- delays {3,5,5,10}, all enabled ----------
        dly = {16'd10, 16'd5, 16'd5, 16'd3}; en = 4'hF; start = 1'b1;
        step();
        check("d3551_E0", got_main(), pk(4'b0000, 16'd0, 1'b1, 1'b0, 1'b0));
        for (int k = 1; k <= 13; k++) begin
            step();
            ech  = {k >= 11, k >= 6, k >= 6, k >= 4};
            ecnt = (k <= 11) ? 16'(k) : 16'd11;
            check($sformatf("d3551_E%0d", k), got_main(),
                  pk(ech, ecnt, k <= 10, k >= 11, 1'b0));
        end
        start = 1'b0;
        step();
        check("d3551_end_idle", got_main(), pk(4'b0000, 16'd0, 1'b0, 1'b0, 1'b0));

        // ---------- table: delay 0 on ch0 only, then early abort ----------
        d2 = {16'd7, 16'd7, 16'd7, 16'd0};
        d3 = {16'd20, 16'd20, 16'd20, 16'd2};
        vecs[0]  = mk(1'b1, d2, 4'b0001, 4'b0000, 16'd0, 1'b1, 1'b0, 1'b0);
        vecs[1]  = mk(1'b1, d2, 4'b0001, 4'b1111, 16'd1, 1'b0, 1'b1, 1'b0);
        vecs[2]  = mk(1'b1, d2, 4'b0001, 4'b1111, 16'd1, 1'b0, 1'b1, 1'b0);
        vecs[3]  = mk(1'b0, d2, 4'b0001, 4'b0000, 16'd0, 1'b0, 1'b0, 1'b0);
        vecs[4]  = mk(1'b0, d2, 4'b0001, 4'b0000, 16'd0, 1'b0, 1'b0, 1'b0);
        vecs[5]  = mk(1'b1, d3, 4'b1111, 4'b0000, 16'd0, 1'b1, 1'b0, 1'b0);
        vecs[6]  = mk(1'b1, d3, 4'b1111, 4'b0000, 16'd1, 1'b1, 1'b0, 1'b0);
        vecs[7]  = mk(1'b1, d3, 4'b1111, 4'b0000, 16'd2, 1'b1, 1'b0, 1'b0);
        vecs[8]  = mk(1'b1, d3, 4'b1111, 4'b0001, 16'd3, 1'b1, 1'b0, 1'b0);
        vecs[9]  = mk(1'b1, d3, 4'b1111, 4'b0001, 16'd4, 1'b1, 1'b0, 1'b0);
        vecs[10] = mk(1'b1, d3, 4'b1111, 4'b0001, 16'd5, 1'b1, 1'b0, 1'b0);
        vecs[11] = mk(1'b1, d3, 4'b1111, 4'b0001, 16'd6, 1'b1, 1'b0, 1'b0);
        vecs[12] = mk(1'b1, d3, 4'b1111, 4'b0001, 16'd7, 1'b1, 1'b0, 1'b0);
        vecs[13] = mk(1'b0, d3, 4'b1111, 4'b0000, 16'd0, 1'b0, 1'b0, 1'b1);
        vecs[14] = mk(1'b0, d3, 4'b1111, 4'b0000, 16'd0, 1'b0, 1'b0, 1'b0);
        for (int v = 0; v < 15; v++) begin
            start = vecs[v].start; dly = vecs[v].dly; en = vecs[v].en;
            step();
            check($sformatf("table_%0d", v), got_main(),
                  pk(vecs[v].ch, vecs[v].cnt, vecs[v].busy, vecs[v].done, vecs[v].abort));
        end

        // ---------- CNT_W=4: delay 15 on ch0, others 1, two identical runs ----------
        dly4 = {4'd1, 4'd1, 4'd1, 4'd15}; en4 = 4'hF;
        for (int r = 0; r < 2; r++) begin
            start4 = 1'b1;
            step();
            check($sformatf("w4_r%0d_E0", r), got_w4(), pk(4'b0000, 16'd0, 1'b1, 1'b0, 1'b0));
            for (int k = 1; k <= 18; k++) begin
                step();
                ech  = {k >= 2, k >= 2, k >= 2, k >= 16};
                ecnt = (k <= 15) ? 16'(k) : 16'd15;
                check($sformatf("w4_r%0d_E%0d", r, k), got_w4(),
                      pk(ech, ecnt, k <= 15, k >= 16, 1'b0));
            end
            start4 = 1'b0;
            step();
            check($sformatf("w4_r%0d_idle", r), got_w4(), pk(4'b0000, 16'd0, 1'b0, 1'b0, 1'b0));
        end

        // ---------- inputs changed mid-run follow the start-edge snapshot ----------
        // ch0 D=2 -> E3, ch1 D=6 -> E7, ch2 disabled -> E1, ch3 D=3 -> E4
        dly = {16'd3, 16'd9, 16'd6, 16'd2}; en = 4'b1011; start = 1'b1;
        step();
        dly = {16'd1, 16'd1, 16'd1, 16'd1}; en = 4'b0000;
        check("snap_E0", got_main(), pk(4'b0000, 16'd0, 1'b1, 1'b0, 1'b0));
        for (int k = 1; k <= 8; k++) begin
            step();
            dly = 64'(k) * 64'h0001_0001_0001_0001;
            ech = {k >= 4, k >= 1, k >= 7, k >= 3};
            ecnt = (k <= 7) ? 16'(k) : 16'd7;
            check($sformatf("snap_E%0d", k), got_main(), pk(ech, ecnt, k <= 6, k >= 7, 1'b0));
        end
        start = 1'b0;
        step();
        check("snap_idle", got_main(), pk(4'b0000, 16'd0, 1'b0, 1'b0, 1'b0));

        // ---------- asynchronous reset mid-run ----------
        dly = {16'd30, 16'd30, 16'd30, 16'd1}; en = 4'hF; start = 1'b1;
        for (int k = 0; k <= 5; k++) step();
        check("arst_before", got_main(), pk(4'b0001, 16'd5, 1'b1, 1'b0, 1'b0));
        #2;
        rst = 1'b1;
        #1;
        check("arst_immediate", got_main(), pk(4'b0000, 16'd0, 1'b0, 1'b0, 1'b0));
        step();
        check("arst_held", got_main(), pk(4'b0000, 16'd0, 1'b0, 1'b0, 1'b0));
        start = 1'b0;
        rst = 1'b0;
        step();
        check("arst_after", got_main(), pk(4'b0000, 16'd0, 1'b0, 1'b0, 1'b0));

        // ---------- randomized run against the reference model ----------
        do_reset();
        m_active = 1'b0; m_finished = 1'b0; m_abort = 1'b0; m_k = 0; m_last = 0;
        for (int i = 0; i < 4; i++) m_fire[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!m_active) begin
                start = ($urandom_range(0, 3) != 0);
            end else if (!m_finished) begin
                start = ($urandom_range(0, 39) != 0);
            end else begin
                start = ($urandom_range(0, 3) != 0);
            end
            for (int i = 0; i < 4; i++) dly[i*16 +: 16] = 16'($urandom_range(0, 15));
            en = 4'($urandom_range(0, 15));
            step();
            model_edge(start, dly, en);
            kk = c;
            check($sformatf("rand_%0d", kk), got_main(), model_out());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
